clint_timer: RTL
================

Name: clint_timer

Overview:
Parametrised core-local interruptor; next generation of the single-channel machine timer. Provides one shared 64-bit mtime with programmable prescaler and debug freeze, plus per-hart mtimecmp and msip registers. Drives NUM_HARTS timer and software interrupt lines. Sits on the CPU memory-mapped peripheral port with a registered one-cycle read response.

Parameters:
NUM_HARTS, 1, number of hart channels (1..8), each with its own mtimecmp/msip/interrupts
BASE_ADDR, 64'h0200_0000, base address of the register window
TICK_DIV, 1, clock cycles per mtime increment (>=1)
MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of every mtimecmp

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
cen_i  input  1  access request, valid for one cycle
wen_i  input  1  1=write, 0=read (qualified by cen_i)
addr_i  input  64  byte address
wdata_i  input  64  write data
wstrb_i  input  8  byte write enables
time_stop_i  input  1  freeze mtime and prescaler (debug halt)
rdata_o  output  64  read data, valid with rvalid_o
rvalid_o  output  1  response strobe, one cycle after accepted access (reads and writes)
err_o  output  1  with rvalid_o: access was unmapped or misaligned
timer_int_o  output  NUM_HARTS  per-hart timer interrupt
soft_int_o  output  NUM_HARTS  per-hart software interrupt

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high. All state clears immediately on rst assertion.
- Reset values: mtime=0, prescaler count=0, mtimecmp[h]=MTIMECMP_RST, msip[h]=0, rdata_o=0, rvalid_o=0, err_o=0, timer_int_o=0, soft_int_o=0.
- Register map (offset = addr_i - BASE_ADDR; 8-byte aligned only):
  - msip[h] at 0x0000+8*h, bit0 only; other bits read 0, write ignored.
  - mtimecmp[h] at 0x4000+8*h.
  - mtime at 0xBFF8.
- Decode errors: offset outside the map, h>=NUM_HARTS, or addr_i[2:0]!=0 -> no state change, rdata_o=0, err_o=1.
- Access handshake: no backpressure; every cen_i cycle accepted. Next cycle: rvalid_o=1 for exactly one cycle; rdata_o=register value before that cycle's write; err_o per decode. Back-to-back accesses give back-to-back responses. rdata_o holds its value when rvalid_o=0.
- Byte strobes: lane i updated only when wstrb_i[i]=1; unstrobed lanes keep their pre-write value. wstrb_i=0 is a legal no-op write.
- Prescaler: counter 0..TICK_DIV-1, advances each cycle unless time_stop_i=1. mtime += 1 on the cycle the counter is at TICK_DIV-1; counter then returns to 0. TICK_DIV=1: mtime increments every unstopped cycle.
- mtime wraps from all-ones to 0, unsigned. No sticky flag.
- Simultaneous mtime write and increment: the write wins. Unstrobed bytes take the pre-increment value and the prescaler counter clears to 0.
- time_stop_i: mtime and prescaler hold. Register writes still take effect. Interrupt compare continues.
- timer_int_o[h] is registered: timer_int_o[h] <= (mtime >= mtimecmp[h]), unsigned, on current register values. Visible one cycle after the condition becomes true or false. Level, not sticky.
- soft_int_o[h] = msip[h] (register output, combinational pass-through).
- Reset mid-access: the pending response is dropped; rvalid_o=0 after reset.

Test Plan:
- Reset check: assert rst async mid-cycle -> all outputs 0 at once; read mtimecmp[0] -> 64'hFFFF_FFFF_FFFF_FFFF, err_o=0, timer_int_o=0.
- Compare timing: TICK_DIV=1, write mtime=0 and mtimecmp[0]=5 -> timer_int_o[0] rises exactly one cycle after mtime==5. Then write mtimecmp[0]=100 -> falls one cycle after the write lands.
- Prescaler and freeze: TICK_DIV=4 -> mtime increments every 4th cycle. Hold time_stop_i for 10 cycles -> mtime unchanged; resumes the same prescaler phase.
- Strobes and collision: mtime=0x11 incrementing; write wdata=0xAABB with wstrb=8'h02 on an increment cycle -> mtime=0xAA11, prescaler cleared.
- Multi-hart and software interrupts: NUM_HARTS=4, write msip[2]=1 -> soft_int_o=4'b0100. Read msip[2] -> 1. Write msip[4] -> err_o=1, no change.
- Wrap and errors: mtime=64'hFFFF_FFFF_FFFF_FFFF, mtimecmp[0]=64'hFFFF_FFFF_FFFF_FFFF -> int=1, then mtime=0 -> int drops the next cycle. Read addr BASE+0xBFF9 -> rvalid_o=1, err_o=1, rdata_o=0.

Source files
------------

// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor with one shared 64-bit mtime (prescaled, freezable)
//   and NUM_HARTS sets of mtimecmp/msip driving per-hart timer and software interrupts.
// Ports: clk/rst (async active-high); cen_i/wen_i/addr_i/wdata_i/wstrb_i access request;
//   rdata_o/rvalid_o/err_o registered response one cycle later (never backpressures);
//   time_stop_i debug freeze; timer_int_o/soft_int_o per-hart interrupt lines.
module clint_timer #(
  parameter int          NUM_HARTS    = 1,
  parameter logic [63:0] BASE_ADDR    = 64'h0200_0000,
  parameter int          TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen_i,
  input  logic                 wen_i,
  input  logic [63:0]          addr_i,
  input  logic [63:0]          wdata_i,
  input  logic [7:0]           wstrb_i,
  input  logic                 time_stop_i,
  output logic [63:0]          rdata_o,
  output logic                 rvalid_o,
  output logic                 err_o,
  output logic [NUM_HARTS-1:0] timer_int_o,
  output logic [NUM_HARTS-1:0] soft_int_o
);

  localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  // Decode works on 8-byte word offsets from the window base.
  localparam logic [60:0] CMP_WORD   = 61'h800;   // byte offset 0x4000
  localparam logic [60:0] MTIME_WORD = 61'h17FF;  // byte offset 0xBFF8
  localparam logic [60:0] NH_WORDS   = 61'(NUM_HARTS);

  logic [63:0]          mtime_q, mtime_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [63:0]          mtimecmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [NUM_HARTS-1:0] tint_q, tint_d;
  logic [63:0]          rdata_q, rdata_d;
  logic                 rvalid_q;
  logic                 err_q, err_d;

  logic [60:0] word_off;
  logic [2:0]  hart_idx;
  logic        aligned;
  logic        sel_msip, sel_cmp, sel_mtime;
  logic        dec_err;
  logic        wr;
  logic [63:0] rd_val;

  // Byte-lane merge: only strobed lanes take the new data.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode and read mux.
  always_comb begin
    word_off  = addr_i[63:3] - BASE_ADDR[63:3];
    aligned   = (addr_i[2:0] == 3'b000);
    sel_msip  = aligned && (word_off < NH_WORDS);
    sel_cmp   = aligned && (word_off >= CMP_WORD) && (word_off < CMP_WORD + NH_WORDS);
    sel_mtime = aligned && (word_off == MTIME_WORD);
    // Both hart banks start on a multiple of 8 words, so the low bits are the hart number.
    hart_idx  = word_off[2:0];
    dec_err   = !(sel_msip || sel_cmp || sel_mtime);
    wr        = cen_i && wen_i && !dec_err;

    rd_val = '0;
    if (sel_mtime) begin
      rd_val = mtime_q;
    end
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hart_idx == 3'(h)) begin
        if (sel_msip) rd_val = {63'd0, msip_q[h]};
        if (sel_cmp)  rd_val = mtimecmp_q[h];
      end
    end
  end

  // mtime and prescaler. A (non-empty) mtime write overrides any increment in the
  // same cycle and restarts the prescaler phase, even while frozen.
  always_comb begin
    mtime_d = mtime_q;
    cnt_d   = cnt_q;
    if (wr && sel_mtime && (wstrb_i != 8'h00)) begin
      mtime_d = merge_bytes(mtime_q, wdata_i, wstrb_i);
      cnt_d   = '0;
    end else if (!time_stop_i) begin
      if (cnt_q == CNT_MAX) begin
        mtime_d = mtime_q + 64'd1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Per-hart registers and interrupt compare (on current register values).
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      msip_d[h]     = msip_q[h];
      mtimecmp_d[h] = mtimecmp_q[h];
      if (wr && (hart_idx == 3'(h))) begin
        if (sel_msip && wstrb_i[0]) msip_d[h] = wdata_i[0];
        if (sel_cmp) mtimecmp_d[h] = merge_bytes(mtimecmp_q[h], wdata_i, wstrb_i);
      end
      tint_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  // Response: read data is the pre-write value; rd_val is already zero on decode errors.
  always_comb begin
    rdata_d = cen_i ? rd_val : rdata_q;
    err_d   = cen_i && dec_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q  <= '0;
      cnt_q    <= '0;
      msip_q   <= '0;
      tint_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= MTIMECMP_RST;
      end
    end else begin
      mtime_q  <= mtime_d;
      cnt_q    <= cnt_d;
      msip_q   <= msip_d;
      tint_q   <= tint_d;
      rdata_q  <= rdata_d;
      rvalid_q <= cen_i;
      err_q    <= err_d;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= mtimecmp_d[h];
      end
    end
  end

  assign rdata_o     = rdata_q;
  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign timer_int_o = tint_q;
  assign soft_int_o  = msip_q;

endmodule
